core_control_ldst_seq: RTL and testbench
========================================

CORE_CONTROL_LDST_SEQ -- requirements
Module: core_control_ldst_seq

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 The block SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin block transfer; sampled only in IDLE.
- regs  in  16  register list; bit i set means register i is transferred.
- base  in  32  base address.
- increment  in  1  1 = ascending (IA/IB), 0 = descending (DA/DB).
- pre_index  in  1  1 = step before access (IB/DB), 0 = step after (IA/DA).
- writeback_req  in  1  base writeback requested.
- mem_ready  in  1  current transfer accepted by memory this cycle.
- abort  in  1  exception; cancel sequence.
- busy  out  1  state is not IDLE.
- pop_valid  out  1  a transfer is presented (state XFER).
- reg_index  out  4  register for the current transfer.
- addr  out  32  word address for the current transfer.
- last  out  1  current transfer is the final one.
- wb_valid  out  1  one-cycle pulse; wb_value is valid.
- wb_value  out  32  new base value.
- done  out  1  one-cycle pulse; sequence finished normally.

Function
REQ-003 States SHALL be IDLE, XFER and WRITEBACK.
REQ-004 When start=1 in IDLE, the block SHALL latch regs, base, increment, pre_index and writeback_req, and compute n = popcount(regs), 5 bits, range 0..16.
REQ-005 The first address SHALL be:
- IA: base
- IB: base+4
- DA: base-4n+4
- DB: base-4n
All arithmetic SHALL be 32-bit modulo 2^32.
REQ-006 The final base SHALL be base+4n when increment=1 and base-4n when increment=0, with 32-bit wrap.
REQ-007 Transfers SHALL go in ascending register index order to ascending addresses, one word per transfer, so addr increases by 4 per accepted transfer regardless of direction.
REQ-008 With n>0, the state SHALL move IDLE->XFER on the cycle after start; reg_index SHALL then be the lowest set bit of the pending list.
REQ-009 In XFER with mem_ready=1, the block SHALL clear the current bit, advance addr by 4 and present the next lowest set bit in the following cycle.
REQ-010 In XFER with mem_ready=0, reg_index, addr and last SHALL hold stable.
REQ-011 last SHALL be 1 exactly when one pending bit remains.
REQ-012 When the last transfer is accepted, the next state SHALL be WRITEBACK if the latched writeback_req=1, otherwise IDLE with done=1 for one cycle.
REQ-013 WRITEBACK SHALL last one cycle with wb_valid=1 and wb_value set to the final base, then go to IDLE with done=1 on that same WRITEBACK cycle.
REQ-014 An empty list (n=0) SHALL cause no transfers: the block SHALL go directly to WRITEBACK (wb_value=base) or IDLE with done=1 on the cycle after start.
REQ-015 start while busy=1 SHALL be ignored, with no relatch.
REQ-016 abort=1 in any state SHALL force IDLE on the next edge with done=0 and wb_valid=0, and SHALL take priority over mem_ready and start in the same cycle.
REQ-017 pop_valid SHALL equal (state==XFER); the block SHALL have no combinational path from mem_ready to any output.
REQ-018 The latency from start to the first pop_valid SHALL be 1 cycle; from the last acceptance to done it SHALL be 1 cycle, or 1 cycle to wb_valid/done when writeback is taken.

Reset
REQ-019 When rst_n=0, the block SHALL asynchronously go to IDLE, and all outputs and internal registers SHALL be 0.
REQ-020 Deassertion of rst_n SHALL be synchronised by the integrator; the block SHALL start in IDLE on the first edge after release.
REQ-021 A reset mid-sequence SHALL discard the pending list with no done or wb_valid pulse.

Verification
REQ-022 IA with writeback:
- stimulus: regs=0x8011, base=0x1000, increment=1, pre_index=0, writeback_req=1, mem_ready=1.
- response: (r0,0x1000), (r4,0x1004), (r15,0x1008); last on r15; wb_value=0x100C; done.
REQ-023 DB with stalls:
- stimulus: regs=0x0006, base=0x2000, increment=0, pre_index=1, mem_ready low for 2 cycles per transfer.
- response: (r1,0x1FF8) held 3 cycles, (r2,0x1FFC); no writeback; done 1 cycle after the last acceptance.
REQ-024 Wrap:
- stimulus: regs=0xFFFF, base=0xFFFFFFF0, IB.
- response: first addr 0xFFFFFFF4; r3 at 0x00000000; wb_value=0x00000030.
REQ-025 Abort:
- stimulus: abort=1 during the second transfer, with mem_ready=1 in the same cycle.
- response: IDLE next cycle; no done; no wb_valid; a subsequent start works normally.
REQ-026 Empty list and start-while-busy:
- stimulus: regs=0, writeback_req=1, base=0x40.
- response: no pop_valid; wb_value=0x40; done.
- stimulus: a second start while busy.
- response: ignored.
REQ-027 Reset mid-transfer:
- stimulus: rst_n low during XFER.
- response: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/core_control_ldst_seq_if.sv
// rtl/core_control_ldst_seq_if.sv - request/transfer/writeback signals of the load/store-multiple sequencer
interface core_control_ldst_seq_if;
    logic        start;
    logic [15:0] regs;
    logic [31:0] base;
    logic        increment;
    logic        pre_index;
    logic        writeback_req;
    logic        mem_ready;
    logic        abort;
    logic        busy;
    logic        pop_valid;
    logic [3:0]  reg_index;
    logic [31:0] addr;
    logic        last;
    logic        wb_valid;
    logic [31:0] wb_value;
    logic        done;

    modport master (
        output start, regs, base, increment, pre_index, writeback_req, mem_ready, abort,
        input  busy, pop_valid, reg_index, addr, last, wb_valid, wb_value, done
    );

    modport slave (
        input  start, regs, base, increment, pre_index, writeback_req, mem_ready, abort,
        output busy, pop_valid, reg_index, addr, last, wb_valid, wb_value, done
    );
endinterface

// File: rtl/core_control_ldst_seq.sv
// rtl/core_control_ldst_seq.sv - LDM/STM block-transfer sequencer with optional base writeback
module core_control_ldst_seq (
    input  logic                    clk,
    input  logic                    rst_n,
    core_control_ldst_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, WRITEBACK = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [15:0] pending;
    logic [31:0] cur_addr;
    logic [31:0] final_base;
    logic        wb_req_q;
    logic        done_q;

    logic [4:0]  n;
    logic [31:0] span;
    logic [31:0] first_addr;
    logic [31:0] end_base;
    logic [3:0]  low_idx;
    logic        is_last;

    always_comb begin
        n = '0;
        for (int i = 0; i < 16; i++) n = n + {4'b0, bus.regs[i]};
    end

    assign span = {25'b0, n, 2'b00};

    // Registers always occupy ascending addresses; only the block's position relative to base moves.
    always_comb begin
        first_addr = bus.base;
        case ({bus.increment, bus.pre_index})
            2'b10:   first_addr = bus.base;
            2'b11:   first_addr = bus.base + 32'd4;
            2'b00:   first_addr = bus.base - span + 32'd4;
            default: first_addr = bus.base - span;
        endcase
    end

    assign end_base = bus.increment ? (bus.base + span) : (bus.base - span);

    always_comb begin
        low_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (pending[i]) low_idx = 4'(i);
        end
    end

    assign is_last = (pending != 16'd0) && ((pending & (pending - 16'd1)) == 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (n != 5'd0)              state_nxt = XFER;
                    else if (bus.writeback_req) state_nxt = WRITEBACK;
                    else                        state_nxt = IDLE;
                end
            end
            XFER: begin
                if (bus.abort)                      state_nxt = IDLE;
                else if (bus.mem_ready && is_last)  state_nxt = wb_req_q ? WRITEBACK : IDLE;
            end
            WRITEBACK: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            cur_addr   <= '0;
            final_base <= '0;
            wb_req_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                pending <= '0;
            end else if (state == IDLE && bus.start) begin
                pending    <= bus.regs;
                cur_addr   <= first_addr;
                final_base <= end_base;
                wb_req_q   <= bus.writeback_req;
                if (n == 5'd0 && !bus.writeback_req) done_q <= 1'b1;
            end else if (state == XFER && bus.mem_ready) begin
                pending  <= pending & (pending - 16'd1);
                cur_addr <= cur_addr + 32'd4;
                if (is_last && !wb_req_q) done_q <= 1'b1;
            end
        end
    end

    // Every output comes from registered state only, so mem_ready never reaches an output.
    always_comb begin
        bus.busy      = (state != IDLE);
        bus.pop_valid = (state == XFER);
        bus.wb_valid  = (state == WRITEBACK);
        bus.done      = done_q || (state == WRITEBACK);
        bus.reg_index = low_idx;
        bus.addr      = cur_addr;
        bus.last      = is_last;
        bus.wb_value  = final_base;
    end
endmodule

// File: tb/tb_core_control_ldst_seq.sv
// tb/tb_core_control_ldst_seq.sv - randomized self-checking bench for core_control_ldst_seq
module tb_core_control_ldst_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass = 0;

    core_control_ldst_seq_if bus ();

    core_control_ldst_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.regs = '0; bus.base = '0; bus.increment = 1'b0;
        bus.pre_index = 1'b0; bus.writeback_req = 1'b0; bus.mem_ready = 1'b0; bus.abort = 1'b0;
    endtask

    // stall < 0 picks a random stall count per transfer; abort_at < 0 means no abort.
    task automatic run_seq(input logic [15:0] r, input logic [31:0] b, input logic inc,
                           input logic pre, input logic wb, input int stall,
                           input int abort_at, input logic busy_start);
        int          n;
        logic [31:0] first;
        logic [31:0] fin;
        int          idx[$];
        logic [31:0] adr[$];
        n     = $countones(r);
        fin   = inc ? b + 32'(4 * n) : b - 32'(4 * n);
        first = inc ? (pre ? b + 32'd4 : b) : (pre ? b - 32'(4 * n) : b - 32'(4 * n) + 32'd4);
        for (int i = 0; i < 16; i++) begin
            if (r[i]) begin
                adr.push_back(first + 32'(4 * idx.size()));
                idx.push_back(i);
            end
        end

        bus.start = 1'b1; bus.regs = r; bus.base = b; bus.increment = inc;
        bus.pre_index = pre; bus.writeback_req = wb;
        tick();
        bus.start = 1'b0;

        for (int k = 0; k < n; k++) begin
            int stalls;
            stalls = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            for (int s = 0; s <= stalls; s++) begin
                check("pop_valid", 32'(bus.pop_valid), 32'd1);
                check("reg_index", 32'(bus.reg_index), 32'(idx[k]));
                check("addr", bus.addr, adr[k]);
                check("last", 32'(bus.last), 32'(k == n - 1));
                if (busy_start && k == 0 && s == 0) begin
                    bus.start = 1'b1; bus.regs = ~r; bus.base = ~b;
                    bus.increment = ~inc; bus.writeback_req = ~wb;
                end
                bus.mem_ready = (s == stalls);
                bus.abort     = (s == stalls) && (k == abort_at);
                tick();
                bus.start = 1'b0; bus.mem_ready = 1'b0; bus.abort = 1'b0;
            end
            if (k == abort_at) begin
                check("abort_busy", 32'(bus.busy), 32'd0);
                check("abort_done", 32'(bus.done), 32'd0);
                check("abort_wb", 32'(bus.wb_valid), 32'd0);
                tick();
                check("abort_done2", 32'(bus.done), 32'd0);
                return;
            end
        end

        check("end_pop_valid", 32'(bus.pop_valid), 32'd0);
        if (wb) begin
            check("wb_valid", 32'(bus.wb_valid), 32'd1);
            check("wb_value", bus.wb_value, fin);
            check("wb_done", 32'(bus.done), 32'd1);
            if (busy_start) begin
                bus.start = 1'b1; bus.regs = 16'h00FF;
            end
            tick();
            bus.start = 1'b0;
            check("wb_after_busy", 32'(bus.busy), 32'd0);
            check("wb_after_valid", 32'(bus.wb_valid), 32'd0);
        end else begin
            check("done", 32'(bus.done), 32'd1);
            check("done_busy", 32'(bus.busy), 32'd0);
            check("done_no_wb", 32'(bus.wb_valid), 32'd0);
            tick();
        end
        check("done_pulse", 32'(bus.done), 32'd0);
    endtask

    initial begin
        idle_inputs();
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_wb_value", bus.wb_value, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        run_seq(16'h8011, 32'h0000_1000, 1'b1, 1'b0, 1'b1, 0, -1, 1'b0);
        run_seq(16'h0006, 32'h0000_2000, 1'b0, 1'b1, 1'b0, 2, -1, 1'b0);
        run_seq(16'hFFFF, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b1, 0, -1, 1'b0);
        run_seq(16'h0F0F, 32'h0000_5000, 1'b1, 1'b0, 1'b1, 0, 1, 1'b0);
        run_seq(16'h0F0F, 32'h0000_5000, 1'b1, 1'b0, 1'b1, 1, -1, 1'b0);
        run_seq(16'h0000, 32'h0000_0040, 1'b1, 1'b0, 1'b1, 0, -1, 1'b1);
        run_seq(16'h0000, 32'h0000_0080, 1'b0, 1'b1, 1'b0, 0, -1, 1'b0);
        run_seq(16'h0421, 32'h0000_7000, 1'b0, 1'b0, 1'b1, 1, -1, 1'b1);

        bus.start = 1'b1; bus.regs = 16'h00F0; bus.base = 32'h3000;
        bus.increment = 1'b1; bus.pre_index = 1'b0; bus.writeback_req = 1'b1;
        tick();
        bus.start = 1'b0;
        check("pre_rst_pop_valid", 32'(bus.pop_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_pop_valid", 32'(bus.pop_valid), 32'd0);
        check("mid_rst_reg_index", 32'(bus.reg_index), 32'd0);
        check("mid_rst_addr", bus.addr, 32'd0);
        check("mid_rst_last", 32'(bus.last), 32'd0);
        check("mid_rst_wb", 32'(bus.wb_valid) | 32'(bus.done), 32'd0);
        check("mid_rst_wb_value", bus.wb_value, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rel_busy", 32'(bus.busy), 32'd0);
        check("rel_done", 32'(bus.done), 32'd0);
        run_seq(16'h1234, 32'h0000_9000, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [15:0] r;
            int          ab;
            r  = 16'($urandom);
            if ($urandom_range(0, 5) == 0) r = 16'(1 << $urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) r = 16'h0000;
            ab = ($urandom_range(0, 4) == 0 && r != 0) ? int'($urandom_range(0, $countones(r) - 1)) : -1;
            run_seq(r, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), -1, ab,
                    1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
